// File: rtl/uart_rx.sv
// Receive-only 8N1 UART that pairs with uart_tx. Each frame is sampled at mid-bit,
// and the receiver reports either a good byte or a framing error.
module uart_rx #(
  parameter int clock_frequency = 12000000,
  parameter int baud_rate       = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int          CPB     = clock_frequency / baud_rate;
  localparam int          HALF    = CPB / 2;
  localparam logic [15:0] CPB_M1  = 16'(CPB - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic        rx_meta_q, rx_s_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] sync_cnt_q, sync_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        cnt_zero;

  assign cnt_zero = (sync_cnt_q == 16'd0);

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = cnt_zero ? sync_cnt_q : sync_cnt_q - 16'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          sync_cnt_d = HALF_M1;
          state_d    = START;
        end
      end
      START: begin
        // A start bit that is no longer low at mid-bit is treated as line noise.
        if (cnt_zero) begin
          if (!rx_s_q) begin
            sync_cnt_d = CPB_M1;
            bit_cnt_d  = 3'd0;
            state_d    = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shift_d    = {rx_s_q, shift_q[7:1]};
          sync_cnt_d = CPB_M1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_zero) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end
      // Wait out a held-low line so it cannot be mistaken for new start bits.
      BRK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      sync_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced bit period (cpb=100, half=50).
module tb_uart_rx;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 10000;
  localparam int PER    = CLK_HZ / BAUD;
  localparam int HALF   = PER / 2;
  localparam int LAT    = 9 * PER + HALF + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid, frame_error, busy;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  int valid_cnt = 0, ferr_cnt = 0, viol = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  logic busy_at_valid = 1'b1;
  logic prev_valid = 1'b0, prev_ferr = 1'b0;
  logic [7:0] got_q[$];

  uart_rx #(.clock_frequency(CLK_HZ), .baud_rate(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data),
    .valid(valid), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: records received bytes and flags overlapping or stretched pulses.
  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(data);
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
      busy_at_valid  <= busy;
    end
    if (frame_error) ferr_cnt <= ferr_cnt + 1;
    if ((valid && frame_error) || (valid && prev_valid) || (frame_error && prev_ferr))
      viol <= viol + 1;
    prev_valid <= valid;
    prev_ferr  <= frame_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (per) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  initial begin
    int bad, bcyc, v0, f0, d;
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data",  32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr",  32'(frame_error), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (data !== 8'h00 || valid !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'h0);

    // Ideal frame with latency and busy/valid alignment.
    got_q.delete();
    send_frame(8'hA5, PER, 1'b1);
    repeat (PER) @(negedge clk);
    check("a5_count", 32'(got_q.size()), 32'd1);
    check("a5_data",  32'(data), 32'hA5);
    d = last_valid_cyc - start_cyc;
    check("a5_latency_pm1", 32'(d >= LAT - 1 && d <= LAT + 1), 32'd1);
    check("a5_busy_at_valid", 32'(busy_at_valid), 32'h0);
    check("a5_no_ferr", 32'(ferr_cnt), 32'd0);

    // Glitch shorter than half a bit.
    v0 = valid_cnt; f0 = ferr_cnt; bcyc = 0;
    rx = 1'b0;
    for (int i = 0; i < 24; i++) begin @(negedge clk); if (busy) bcyc++; end
    rx = 1'b1;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (busy) bcyc++; end
    check("glitch_busy_seen", 32'(bcyc > 0 && bcyc <= HALF + 2), 32'd1);
    check("glitch_busy_end", 32'(busy), 32'h0);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_no_ferr",  32'(ferr_cnt - f0), 32'd0);
    check("glitch_data",     32'(data), 32'hA5);

    // Framing error followed by a break, then a good byte.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, PER, 1'b0);
    rx = 1'b0;
    repeat (3 * PER) @(negedge clk);
    check("ferr_pulse",    32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("ferr_data_kept", 32'(data), 32'hA5);
    check("break_busy",    32'(busy), 32'h1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("break_released", 32'(busy), 32'h0);
    got_q.delete();
    send_frame(8'h81, PER, 1'b1);
    repeat (PER) @(negedge clk);
    check("after_ferr_count", 32'(got_q.size()), 32'd1);
    check("after_ferr_data",  32'(data), 32'h81);

    // Back-to-back frames with a slightly slow transmitter.
    got_q.delete(); f0 = ferr_cnt;
    send_frame(8'h00, PER + 2, 1'b1);
    send_frame(8'hFF, PER + 2, 1'b1);
    repeat (PER) @(negedge clk);
    check("b2b_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("b2b_first",  32'(got_q[0]), 32'h00);
      check("b2b_second", 32'(got_q[1]), 32'hFF);
    end
    check("b2b_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Transmitter-style stream, then reset in the middle of a fourth byte.
    got_q.delete();
    send_frame(8'h55, PER, 1'b1);
    send_frame(8'h01, PER, 1'b1);
    send_frame(8'h80, PER, 1'b1);
    repeat (PER) @(negedge clk);
    check("lb_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("lb_b0", 32'(got_q[0]), 32'h55);
      check("lb_b1", 32'(got_q[1]), 32'h01);
      check("lb_b2", 32'(got_q[2]), 32'h80);
    end
    got_q.delete();
    rx = 1'b0;
    repeat (PER) @(negedge clk);
    rx = 1'b1;
    repeat (PER) @(negedge clk);
    rx = 1'b0;
    repeat (2 * PER) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_data",  32'(data), 32'h00);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_ferr",  32'(frame_error), 32'h0);
    check("mid_rst_busy",  32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (12 * PER) @(negedge clk);
    check("mid_rst_no_valid", 32'(got_q.size()), 32'd0);
    send_frame(8'h55, PER, 1'b1);
    repeat (PER) @(negedge clk);
    check("resend_count", 32'(got_q.size()), 32'd1);
    check("resend_data",  32'(data), 32'h55);
    check("pulse_rules",  32'(viol), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
